mem_resp_router: RTL and testbench
==================================

# mem_resp_router

Routes read responses from the shared unified memory back to the correct consumer: the instruction register or the load-data register. The core's memory address mux picks which address (PC or computed address) goes to memory each cycle. This block records that choice for each accepted request in an in-order tag FIFO. When the matching response returns, the block pops the tag and steers the data to the fetch or load path. It sits between memory and the datapath registers, opposite the address mux.

## Interface
- WIDTH, 64, width of response data
- DEPTH, 4, max outstanding requests; power of two, ≥ 2
- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_req_valid  in  1  memory request issued this cycle
- i_req_sel  in  1  address-mux select for this request: 0 = PC (fetch), 1 = computed address (load)
- o_req_ready  out  1  tag FIFO can accept a request
- i_resp_valid  in  1  memory returns read data this cycle
- i_resp_data  in  WIDTH  returned read data
- o_instr_valid  out  1  one-cycle pulse, fetch data valid
- o_instr_data  out  WIDTH  fetch data
- o_load_valid  out  1  one-cycle pulse, load data valid
- o_load_data  out  WIDTH  load data
- o_outstanding  out  $clog2(DEPTH)+1  number of tags held
- o_err  out  1  sticky unexpected-response flag (see Configuration)

## Operation
- Request accept: i_req_valid && o_req_ready pushes i_req_sel at the write pointer. Write pointer wraps modulo DEPTH.
- o_req_ready = (count != DEPTH). It is combinational from the registered count only, with no same-cycle credit from a response pop.
- Response: i_resp_valid with count != 0 pops the head tag. Read pointer wraps modulo DEPTH.
  - Tag 0: the next cycle has o_instr_valid=1 and o_instr_data=i_resp_data.
  - Tag 1: the same applies on the load outputs.
- Data registers load only on their own valid. Otherwise they hold their last value. Valids are low in every cycle without a routed response.
- Accepting a request and popping a response in the same cycle leaves count unchanged, and both pointers advance.
- A response arriving with count == 0 is unexpected, even if a request is accepted in that same cycle. There is no bypass.
  - The response is dropped, no valid is asserted, and FIFO state is unchanged apart from the accepted push.
- At most one of o_instr_valid / o_load_valid is high in any cycle.
- count is kept in $clog2(DEPTH)+1 bits, so DEPTH itself is representable. o_outstanding = count.

## Timing
- Response-to-output latency: exactly 1 cycle, registered.
- Request accept: a push in cycle N is visible in o_outstanding at N+1. That tag can be popped by a response at N+1 or later.
- Reset (i_rst_n low at a rising edge) clears:
  - pointers and count to 0
  - o_instr_valid, o_load_valid, o_err to 0
  - o_instr_data, o_load_data to 0
- Reset mid-operation discards all outstanding tags. Responses to pre-reset requests are treated as unexpected.
- While in reset: o_req_ready=1 (count 0), and responses are ignored.

## Configuration
- MEM_RESP_ROUTER_ERR_EN defined:
  - o_err is set in the cycle after an unexpected response.
  - It stays set until reset.
- Undefined:
  - o_err is tied to 0.
  - Unexpected responses are still silently dropped.
  - The rest of the behaviour is identical.

## Test plan
- Reset, then three requests sel=0,1,0 on consecutive cycles, then responses 0xA, 0xB, 0xC on consecutive cycles.
  - o_instr 0xA, then o_load 0xB, then o_instr 0xC, each one cycle after its response.
  - o_outstanding steps 1,2,3,2,1,0.
- DEPTH=4: issue 4 requests with no responses.
  - o_req_ready=0 and o_outstanding=4.
  - A 5th i_req_valid is not accepted.
  - One response makes o_req_ready=1 the following cycle.
- Full FIFO, simultaneous response and i_req_valid.
  - The request is rejected (ready=0), and the response routes.
  - Next cycle, count=3.
- Count=2, simultaneous accept (sel=1) and response.
  - Count stays 2, the head tag routes, and later responses follow in order.
  - Run 10 such cycles to cover pointer wrap.
- Response with count=0 and i_resp_data=0xDEAD.
  - No valid is asserted, and the data outputs are unchanged.
  - o_err=1 next cycle and stays set, with MEM_RESP_ROUTER_ERR_EN defined.
  - o_err=0 throughout without the macro.
- Reset asserted with 2 tags outstanding.
  - Next cycle: o_outstanding=0, all outputs 0, o_req_ready=1.

Source files
------------

// File: rtl/mem_resp_router.sv
// In-order tag FIFO that steers memory read responses to the fetch or load path.
// Optional sticky unexpected-response flag enabled by defining MEM_RESP_ROUTER_ERR_EN.
module mem_resp_router #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req_valid,
    input  logic                     i_req_sel,
    output logic                     o_req_ready,
    input  logic                     i_resp_valid,
    input  logic [WIDTH-1:0]         i_resp_data,
    output logic                     o_instr_valid,
    output logic [WIDTH-1:0]         o_instr_data,
    output logic                     o_load_valid,
    output logic [WIDTH-1:0]         o_load_data,
    output logic [$clog2(DEPTH):0]   o_outstanding,
    output logic                     o_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic              tag_mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_nxt_s;
    logic              push_s;
    logic              pop_s;
    logic              head_tag_s;
    logic              instr_valid_r;
    logic              load_valid_r;
    logic [WIDTH-1:0]  instr_data_r;
    logic [WIDTH-1:0]  load_data_r;

    // Accept/pop qualification; ready depends on the registered count only.
    always_comb begin
        o_req_ready = (count_r != FULL_COUNT);
        push_s      = i_req_valid && (count_r != FULL_COUNT);
        pop_s       = i_resp_valid && (count_r != {CW{1'b0}});
        head_tag_s  = tag_mem_r[rd_ptr_r];
    end

    // Next occupancy from the push/pop combination.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Tag storage; stale entries are never read because count gates every pop.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            tag_mem_r[wr_ptr_r] <= i_req_sel;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Registered routing of the popped response; data holds unless its own path fires.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            instr_valid_r <= 1'b0;
            load_valid_r  <= 1'b0;
            instr_data_r  <= {WIDTH{1'b0}};
            load_data_r   <= {WIDTH{1'b0}};
        end else begin
            instr_valid_r <= pop_s && !head_tag_s;
            load_valid_r  <= pop_s && head_tag_s;
            if (pop_s && !head_tag_s) begin
                instr_data_r <= i_resp_data;
            end
            if (pop_s && head_tag_s) begin
                load_data_r <= i_resp_data;
            end
        end
    end

`ifdef MEM_RESP_ROUTER_ERR_EN
    logic err_r;

    // Sticky flag for a response that arrives with no tag outstanding.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            err_r <= 1'b0;
        end else if (i_resp_valid && (count_r == {CW{1'b0}})) begin
            err_r <= 1'b1;
        end
    end

    assign o_err = err_r;
`else
    assign o_err = 1'b0;
`endif

    assign o_instr_valid = instr_valid_r;
    assign o_instr_data  = instr_data_r;
    assign o_load_valid  = load_valid_r;
    assign o_load_data   = load_data_r;
    assign o_outstanding = count_r;

endmodule

// File: tb/tb_mem_resp_router.sv
// Self-checking bench for mem_resp_router: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_mem_resp_router;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;

    logic                   clk;
    logic                   rst_n;
    logic                   req_valid;
    logic                   req_sel;
    logic                   req_ready;
    logic                   resp_valid;
    logic [WIDTH-1:0]       resp_data;
    logic                   instr_valid;
    logic [WIDTH-1:0]       instr_data;
    logic                   load_valid;
    logic [WIDTH-1:0]       load_data;
    logic [$clog2(DEPTH):0] outstanding;
    logic                   err;

    int n_checks;
    int n_fails;

    // Reference model state
    bit               tag_q[$];
    bit               exp_instr_valid;
    bit               exp_load_valid;
    logic [WIDTH-1:0] exp_instr_data;
    logic [WIDTH-1:0] exp_load_data;
    bit               exp_err;
    bit               started;

    mem_resp_router #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .i_req_sel     (req_sel),
        .o_req_ready   (req_ready),
        .i_resp_valid  (resp_valid),
        .i_resp_data   (resp_data),
        .o_instr_valid (instr_valid),
        .o_instr_data  (instr_data),
        .o_load_valid  (load_valid),
        .o_load_data   (load_data),
        .o_outstanding (outstanding),
        .o_err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check ready, advance model, check registered outputs.
    task automatic step(input bit rn, input bit rv, input bit sel, input bit pv,
                        input logic [WIDTH-1:0] data);
        int  sz;
        bit  tag;
        rst_n      = rn;
        req_valid  = rv;
        req_sel    = sel;
        resp_valid = pv;
        resp_data  = data;
        #1;
        if (started) check("ready", req_ready, (tag_q.size() != DEPTH));
        @(posedge clk);
        #1;
        started = 1'b1;
        exp_instr_valid = 1'b0;
        exp_load_valid  = 1'b0;
        if (!rn) begin
            tag_q.delete();
            exp_instr_data = '0;
            exp_load_data  = '0;
            exp_err        = 1'b0;
        end else begin
            sz = tag_q.size();
            if (pv && sz > 0) begin
                tag = tag_q.pop_front();
                if (tag) begin
                    exp_load_valid = 1'b1;
                    exp_load_data  = data;
                end else begin
                    exp_instr_valid = 1'b1;
                    exp_instr_data  = data;
                end
            end else if (pv) begin
`ifdef MEM_RESP_ROUTER_ERR_EN
                exp_err = 1'b1;
`endif
            end
            if (rv && sz < DEPTH) tag_q.push_back(sel);
        end
        check("outstanding", outstanding, tag_q.size());
        check("instr_valid", instr_valid, exp_instr_valid);
        check("load_valid",  load_valid,  exp_load_valid);
        check("instr_data",  instr_data,  exp_instr_data);
        check("load_data",   load_data,   exp_load_data);
        check("err",         err,         exp_err);
        check("one_hot",     instr_valid & load_valid, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        started  = 1'b0;
        exp_instr_data = '0;
        exp_load_data  = '0;
        exp_err = 1'b0;
        rst_n = 1'b0; req_valid = 1'b0; req_sel = 1'b0; resp_valid = 1'b0; resp_data = '0;

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("reset_outstanding", outstanding, 0);
        check("reset_ready", req_ready, 1);

        // In-order routing sel 0,1,0 then data A,B,C
        step(1, 1, 0, 0, 0);
        check("seq_cnt1", outstanding, 1);
        step(1, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        check("seq_cnt3", outstanding, 3);
        step(1, 0, 0, 1, 64'hA);
        check("seq_instr_a", instr_data, 64'hA);
        check("seq_instr_a_v", instr_valid, 1);
        step(1, 0, 0, 1, 64'hB);
        check("seq_load_b", load_data, 64'hB);
        check("seq_load_b_v", load_valid, 1);
        step(1, 0, 0, 1, 64'hC);
        check("seq_instr_c", instr_data, 64'hC);
        check("seq_cnt0", outstanding, 0);

        // Fill to DEPTH, reject the fifth, then full with simultaneous request + response
        for (int i = 0; i < DEPTH; i++) step(1, 1, i[0], 0, 0);
        check("full_ready", req_ready, 0);
        check("full_cnt", outstanding, DEPTH);
        step(1, 1, 1, 0, 0);
        check("full_reject_cnt", outstanding, DEPTH);
        step(1, 1, 1, 1, 64'h11);
        check("full_pop_cnt", outstanding, DEPTH - 1);
        check("full_pop_route", instr_valid, 1);
        check("full_ready_back", req_ready, 1);

        // Drain to 2, then 10 cycles of simultaneous accept + response
        step(1, 0, 0, 1, 64'h22);
        check("drain_cnt2", outstanding, 2);
        for (int i = 0; i < 10; i++) step(1, 1, 1, 1, {$urandom, $urandom});
        check("simul_cnt2", outstanding, 2);
        step(1, 0, 0, 1, 64'h33);
        step(1, 0, 0, 1, 64'h44);
        check("simul_tail_load", load_data, 64'h44);

        // Unexpected response with empty FIFO
        step(1, 0, 0, 1, 64'hDEAD);
        check("unexp_no_instr", instr_valid, 0);
        check("unexp_no_load", load_valid, 0);
        check("unexp_load_hold", load_data, 64'h44);
`ifdef MEM_RESP_ROUTER_ERR_EN
        check("unexp_err", err, 1);
`else
        check("unexp_err", err, 0);
`endif
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Reset with two tags outstanding
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        check("pre_reset_cnt", outstanding, 2);
        step(0, 0, 0, 1, 64'h55);
        check("rst_cnt", outstanding, 0);
        check("rst_ready", req_ready, 1);
        check("rst_instr_data", instr_data, 0);
        check("rst_load_data", load_data, 0);
        check("rst_err", err, 0);
        step(1, 0, 0, 1, 64'h66);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 2) != 0), {$urandom, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
